// File: rtl/enc_pkg.sv
// Shared encoder definitions: control FSM encoding and common widths/defaults,
// used by the input filter and the quadrature decoder.
package enc_pkg;

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } enc_state_t;

  localparam int GLITCH_CNT_W     = 16;
  localparam int SYNC_STAGES_DEF  = 2;

endpackage

// File: rtl/enc_chan_filter.sv
// One encoder channel: synchroniser, persistence filter, filtered level,
// registered rise/fall pulses and combinational accept/glitch strobes.
module enc_chan_filter
  import enc_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W      = 8
) (
  input  logic              I_CLK_100MHZ,
  input  logic              I_RST,
  input  logic              raw,
  input  logic              run,
  input  logic [FILT_W-1:0] filt_len,
  output logic              level,
  output logic              rise,
  output logic              fall,
  output logic              accept,
  output logic              glitch
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_W-1:0]      cnt;
  logic [FILT_W-1:0]      eff_len;
  logic [FILT_W:0]        cnt_inc;
  logic                   s;

  assign s       = sync_q[SYNC_STAGES-1];
  assign eff_len = (filt_len == '0) ? {{(FILT_W-1){1'b0}}, 1'b1} : filt_len;
  assign cnt_inc = {1'b0, cnt} + {{FILT_W{1'b0}}, 1'b1};

  // Accept on the cycle the difference reaches its eff_len-th consecutive cycle;
  // a shortened length takes effect on the very next comparison.
  assign accept = run && (s != level) && (cnt_inc >= {1'b0, eff_len});
  assign glitch = run && (s == level) && (cnt != '0);

  always_ff @(posedge I_CLK_100MHZ) begin
    if (I_RST) begin
      sync_q <= '0;
      cnt    <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (!run) begin
        level <= s;
        cnt   <= '0;
      end else if (s == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= s;
        cnt   <= '0;
        rise  <= s;
        fall  <= ~s;
      end else if (cnt != '1) begin
        cnt <= cnt_inc[FILT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/enc_input_filter.sv
// Encoder input conditioning: three filtered channels, PRIME/RUN control,
// saturating glitch accumulator and sticky A/B simultaneous-change flag.
module enc_input_filter
  import enc_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_W      = 8
) (
  input  logic                    I_CLK_100MHZ,
  input  logic                    I_RST,
  input  logic                    I_ENC_A,
  input  logic                    I_ENC_B,
  input  logic                    I_ENC_Z,
  input  logic [FILT_W-1:0]       I_FILT_LEN,
  input  logic                    I_ERR_CLR,
  output logic                    O_VALID,
  output logic                    O_ENC_A,
  output logic                    O_ENC_B,
  output logic                    O_ENC_Z,
  output logic                    O_A_RISE,
  output logic                    O_A_FALL,
  output logic                    O_B_RISE,
  output logic                    O_B_FALL,
  output logic                    O_Z_PULSE,
  output logic                    O_ERR_ILLEGAL,
  output logic [GLITCH_CNT_W-1:0] O_GLITCH_CNT,
  output enc_state_t              O_DBG_STATE
);

  enc_state_t              state;
  logic [2:0]              prime_cnt;
  logic                    run;
  logic                    a_acc, b_acc, z_acc;
  logic                    a_gl, b_gl, z_gl;
  logic                    z_fall;
  logic [1:0]              g_inc;
  logic [GLITCH_CNT_W-1:0] g_base;
  logic [GLITCH_CNT_W:0]   g_sum;
  logic                    unused_z;

  assign run         = (state == ST_RUN);
  assign O_VALID     = run;
  assign O_DBG_STATE = state;
  assign unused_z    = &{1'b0, z_fall, z_acc};

  enc_chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_chan_a (
    .I_CLK_100MHZ(I_CLK_100MHZ), .I_RST(I_RST), .raw(I_ENC_A), .run(run),
    .filt_len(I_FILT_LEN), .level(O_ENC_A), .rise(O_A_RISE), .fall(O_A_FALL),
    .accept(a_acc), .glitch(a_gl)
  );

  enc_chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_chan_b (
    .I_CLK_100MHZ(I_CLK_100MHZ), .I_RST(I_RST), .raw(I_ENC_B), .run(run),
    .filt_len(I_FILT_LEN), .level(O_ENC_B), .rise(O_B_RISE), .fall(O_B_FALL),
    .accept(b_acc), .glitch(b_gl)
  );

  enc_chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_chan_z (
    .I_CLK_100MHZ(I_CLK_100MHZ), .I_RST(I_RST), .raw(I_ENC_Z), .run(run),
    .filt_len(I_FILT_LEN), .level(O_ENC_Z), .rise(O_Z_PULSE), .fall(z_fall),
    .accept(z_acc), .glitch(z_gl)
  );

  // A clear in the same cycle as new glitches keeps only this cycle's increment.
  assign g_inc  = {1'b0, a_gl} + {1'b0, b_gl} + {1'b0, z_gl};
  assign g_base = I_ERR_CLR ? '0 : O_GLITCH_CNT;
  assign g_sum  = {1'b0, g_base} + {{(GLITCH_CNT_W-1){1'b0}}, g_inc};

  always_ff @(posedge I_CLK_100MHZ) begin
    if (I_RST) begin
      state         <= ST_PRIME;
      prime_cnt     <= '0;
      O_ERR_ILLEGAL <= 1'b0;
      O_GLITCH_CNT  <= '0;
    end else begin
      case (state)
        ST_PRIME: begin
          if (prime_cnt == 3'(SYNC_STAGES)) state <= ST_RUN;
          else prime_cnt <= prime_cnt + 3'd1;
        end
        ST_RUN:   state <= ST_RUN;
        default:  state <= ST_PRIME;
      endcase
      if (a_acc && b_acc) O_ERR_ILLEGAL <= 1'b1;
      else if (I_ERR_CLR) O_ERR_ILLEGAL <= 1'b0;
      O_GLITCH_CNT <= g_sum[GLITCH_CNT_W] ? '1 : g_sum[GLITCH_CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_enc_input_filter.sv
// Directed bench for enc_input_filter (SYNC_STAGES=2, FILT_W=8) with
// hand-computed expectations checked by immediate assertions.
module tb_enc_input_filter;
  import enc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enc_a, enc_b, enc_z;
  logic [7:0]  filt_len;
  logic        err_clr;
  logic        o_valid, o_a, o_b, o_z;
  logic        a_rise, a_fall, b_rise, b_fall, z_pulse;
  logic        err;
  logic [15:0] gcnt;
  enc_state_t  dbg_state;
  logic [4:0]  pulses;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign pulses = {a_rise, a_fall, b_rise, b_fall, z_pulse};

  enc_input_filter #(.SYNC_STAGES(2), .FILT_W(8)) dut (
    .I_CLK_100MHZ(clk), .I_RST(rst),
    .I_ENC_A(enc_a), .I_ENC_B(enc_b), .I_ENC_Z(enc_z),
    .I_FILT_LEN(filt_len), .I_ERR_CLR(err_clr),
    .O_VALID(o_valid), .O_ENC_A(o_a), .O_ENC_B(o_b), .O_ENC_Z(o_z),
    .O_A_RISE(a_rise), .O_A_FALL(a_fall), .O_B_RISE(b_rise), .O_B_FALL(b_fall),
    .O_Z_PULSE(z_pulse), .O_ERR_ILLEGAL(err), .O_GLITCH_CNT(gcnt),
    .O_DBG_STATE(dbg_state)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; enc_a = 1'b1; enc_b = 1'b0; enc_z = 1'b0;
    filt_len = 8'd4; err_clr = 1'b0;
    step(3);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_levels", {29'd0, o_a, o_b, o_z}, 0);
    chk("rst_pulses", 32'(pulses), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_gcnt", 32'(gcnt), 0);
    chk("rst_state", 32'(dbg_state), 32'(ST_PRIME));

    // Release with A=1,B=0 held: valid after 3 cycles, A loaded without pulses
    rst = 1'b0;
    step(1);
    chk("prime1_valid", 32'(o_valid), 0);
    chk("prime1_pulses", 32'(pulses), 0);
    step(1);
    chk("prime2_valid", 32'(o_valid), 0);
    step(1);
    chk("prime3_valid", 32'(o_valid), 1);
    chk("prime3_state", 32'(dbg_state), 32'(ST_RUN));
    chk("prime3_a", 32'(o_a), 1);
    chk("prime3_b", 32'(o_b), 0);
    chk("prime3_pulses", 32'(pulses), 0);

    // FILT_LEN=4: fall then rise on A, 6 cycles each
    enc_a = 1'b0;
    step(5);
    chk("afall_early", {30'd0, o_a, a_fall}, 32'b10);
    step(1);
    chk("afall_level", 32'(o_a), 0);
    chk("afall_pulse", 32'(pulses), 32'b01000);
    enc_a = 1'b1;
    step(1);
    chk("afall_once", 32'(pulses), 0);
    step(4);
    chk("arise_early", {30'd0, o_a, a_rise}, 0);
    step(1);
    chk("arise_level", 32'(o_a), 1);
    chk("arise_pulse", 32'(pulses), 32'b10000);
    step(1);
    chk("arise_once", 32'(pulses), 0);
    chk("arise_noerr", 32'(err), 0);

    // 3-cycle B pulse with FILT_LEN=4: rejected, one glitch
    enc_b = 1'b1;
    step(3);
    enc_b = 1'b0;
    step(2);
    chk("bglitch_pre", 32'(gcnt), 0);
    step(1);
    chk("bglitch_cnt", 32'(gcnt), 1);
    chk("bglitch_level", 32'(o_b), 0);
    step(2);
    chk("bglitch_pulses", 32'(pulses), 0);

    // FILT_LEN=2: 1-cycle pulses on A,B,Z together score 3 glitches each
    filt_len = 8'd2;
    for (int i = 0; i < 21844; i++) begin
      enc_a = 1'b0; enc_b = 1'b1; enc_z = 1'b1;
      step(1);
      enc_a = 1'b1; enc_b = 1'b0; enc_z = 1'b0;
      step(1);
    end
    step(4);
    chk("gcnt_65533", 32'(gcnt), 65533);
    chk("gcnt_levels", {29'd0, o_a, o_b, o_z}, 32'b100);
    enc_a = 1'b0; enc_b = 1'b1; enc_z = 1'b1;
    step(1);
    enc_a = 1'b1; enc_b = 1'b0; enc_z = 1'b0;
    step(5);
    chk("gcnt_sat", 32'(gcnt), 32'hFFFF);
    enc_b = 1'b1;
    step(1);
    enc_b = 1'b0;
    step(5);
    chk("gcnt_sat_hold", 32'(gcnt), 32'hFFFF);
    chk("gcnt_noerr", 32'(err), 0);

    // FILT_LEN=1: simultaneous A/B change flags the error
    filt_len = 8'd1;
    enc_a = 1'b0; enc_b = 1'b1;
    step(2);
    chk("ill_pre", {29'd0, o_a, o_b, err}, 32'b100);
    step(1);
    chk("ill_levels", {30'd0, o_a, o_b}, 32'b01);
    chk("ill_err", 32'(err), 1);
    chk("ill_pulses", 32'(pulses), 32'b01100);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("clr_err", 32'(err), 0);
    chk("clr_gcnt", 32'(gcnt), 0);

    // Set and clear on the same cycle: set wins
    enc_a = 1'b1; enc_b = 1'b0;
    step(2);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("setclr_err", 32'(err), 1);
    chk("setclr_gcnt", 32'(gcnt), 0);
    chk("setclr_levels", {30'd0, o_a, o_b}, 32'b10);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("setclr_clear", 32'(err), 0);

    // Single-channel change is legal
    enc_a = 1'b0;
    step(3);
    chk("single_a", 32'(o_a), 0);
    chk("single_pulse", 32'(pulses), 32'b01000);
    chk("single_noerr", 32'(err), 0);

    // FILT_LEN=0 behaves as 1
    filt_len = 8'd0;
    enc_b = 1'b1;
    step(2);
    chk("len0_early", 32'(o_b), 0);
    step(1);
    chk("len0_rise", {31'd0, o_b}, 1);
    chk("len0_pulse", 32'(pulses), 32'b00100);
    enc_b = 1'b0;
    step(3);
    chk("len0_fall", 32'(pulses), 32'b00010);

    // FILT_LEN=10 with B pending 5 cycles, shortened to 3: accept next cycle
    filt_len = 8'd10;
    enc_b = 1'b1;
    step(7);
    chk("shorten_pre", 32'(o_b), 0);
    filt_len = 8'd3;
    step(1);
    chk("shorten_level", 32'(o_b), 1);
    chk("shorten_pulse", 32'(pulses), 32'b00100);
    step(1);
    chk("shorten_once", 32'(pulses), 0);

    // Reset 2 cycles into a pending Z acceptance
    filt_len = 8'd4;
    enc_z = 1'b1;
    step(4);
    chk("zpend_level", 32'(o_z), 0);
    rst = 1'b1;
    step(1);
    chk("zrst_state", {28'd0, o_valid, o_z, z_pulse, err}, 0);
    chk("zrst_gcnt", 32'(gcnt), 0);
    step(1);
    rst = 1'b0;
    step(1);
    chk("zrel1", {29'd0, o_valid, o_z, z_pulse}, 0);
    step(1);
    chk("zrel2", {29'd0, o_valid, o_z, z_pulse}, 0);
    step(1);
    chk("zrel3", {29'd0, o_valid, o_z, z_pulse}, 32'b110);
    chk("zrel3_b", 32'(o_b), 1);
    chk("zrel3_pulses", 32'(pulses), 0);
    step(3);
    chk("zrel_quiet", 32'(pulses), 0);
    chk("zrel_z", 32'(o_z), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/enc_input_filter.md
ENC_INPUT_FILTER -- requirements
Module: enc_input_filter

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchroniser flops per raw input (legal 2..4).
REQ-002 Parameter FILT_W, default 8, width of the filter-length input.
REQ-003 Port I_CLK_100MHZ  in  1  system clock, 100 MHz.
REQ-004 Port I_RST  in  1  reset: synchronous, active-high.
REQ-005 Port I_ENC_A / I_ENC_B / I_ENC_Z  in  1 each  raw asynchronous encoder pins.
REQ-006 Port I_FILT_LEN  in  FILT_W  number of consecutive stable cycles needed to accept a level; 0 and 1 both mean no filtering.
REQ-007 Port I_ERR_CLR  in  1  one-cycle clear of the error flag and the glitch counter.
REQ-008 Port O_VALID  out  1  filtered outputs are trustworthy.
REQ-009 Port O_ENC_A / O_ENC_B / O_ENC_Z  out  1 each  filtered levels.
REQ-010 Port O_A_RISE / O_A_FALL / O_B_RISE / O_B_FALL  out  1 each  one-cycle edge pulses.
REQ-011 Port O_Z_PULSE  out  1  one-cycle pulse on accepted Z rise.
REQ-012 Port O_ERR_ILLEGAL  out  1  sticky flag: A and B both changed in the same cycle.
REQ-013 Port O_GLITCH_CNT  out  16  saturating count of rejected pulses.

Function
REQ-014 Each raw input SHALL pass through SYNC_STAGES flops; the last flop is the channel's sampled value S.
REQ-015 Control FSM states: PRIME, RUN; PRIME entered on reset.
REQ-016 PRIME: load each filtered level directly from S every cycle, with no edge pulses, no error and no glitch counting; after SYNC_STAGES+1 cycles go to RUN.
REQ-017 O_VALID SHALL be 0 in PRIME and 1 in RUN.
REQ-018 RUN, per channel: if S equals the filtered level, clear the stable counter; otherwise increment it, saturating at all-ones.
REQ-019 A channel's filtered level SHALL take the value of S on the cycle in which S has differed from it for max(I_FILT_LEN,1) consecutive cycles; the counter clears on that cycle.
REQ-020 Latency: raw pin change to filtered-level change = SYNC_STAGES + max(I_FILT_LEN,1) cycles.
REQ-021 Edge and Z pulses SHALL be registered and asserted in the same cycle the filtered level changes, high for exactly 1 cycle.
REQ-022 Glitch: when S returns to the filtered level with counter nonzero, before acceptance, that channel scores one glitch.
REQ-023 O_GLITCH_CNT SHALL add the number of channels scoring a glitch in a cycle (0..3) and saturate at 0xFFFF.
REQ-024 If I_FILT_LEN changes in RUN, the new value applies immediately; a counter already at or above the new length accepts on the next cycle.
REQ-025 O_ERR_ILLEGAL SHALL set on a cycle where O_ENC_A and O_ENC_B both change.
REQ-026 Set and I_ERR_CLR in the same cycle: the flag SHALL end up set and the counter SHALL end up equal to that cycle's glitch increment.
REQ-027 Z SHALL be filtered identically to A/B, but excluded from the illegal-transition check.

Reset
REQ-028 While I_RST is 1, all of the following SHALL clear to 0: synchroniser flops, stable counters, filtered levels, pulses, O_ERR_ILLEGAL, O_GLITCH_CNT and O_VALID; the FSM enters PRIME.
REQ-029 Reset asserted mid-filter SHALL discard partial counts; no pulse SHALL appear on the cycle after release.

Structure
REQ-030 Shared package enc_pkg SHALL hold the FSM state encoding, GLITCH_CNT_W = 16 and the SYNC_STAGES default, shared with the quadrature decoder.
REQ-031 One sub-module, enc_chan_filter, holds the synchroniser, stable counter, level, rise/fall and glitch strobe; it is instantiated three times (A, B, Z).
REQ-032 The top level holds the FSM, glitch accumulator and illegal-transition detector.

Verification
REQ-033 Reset release with A=1, B=0 held, FILT_LEN=4 -> O_VALID rises 3 cycles after release; O_ENC_A=1 with no pulses.
REQ-034 RUN, FILT_LEN=4, A rises and holds -> O_ENC_A rises and O_A_RISE pulses once, exactly 6 cycles after the pin edge.
REQ-035 FILT_LEN=4, 3-cycle high pulse on B -> O_ENC_B unchanged and O_GLITCH_CNT increments by 1; with 0xFFFF preloaded by 65535 glitches it stays 0xFFFF.
REQ-036 FILT_LEN=1, A and B toggled in the same cycle -> both change together and O_ERR_ILLEGAL=1; I_ERR_CLR clears the flag and sets the counter to 0.
REQ-037 FILT_LEN=10, B high for 5 cycles, then FILT_LEN written to 3 -> O_ENC_B changes on the next cycle.
REQ-038 I_RST asserted 2 cycles into a pending Z acceptance -> no O_Z_PULSE; O_ENC_Z=0 until PRIME reloads it.
